// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encodings, mux
// select values, the data word type and a width helper for the counters.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BUSY_IF = 2'd1;
   localparam logic [1:0] ST_BUSY_D  = 2'd2;

   localparam logic SEL_IF = 1'b0;
   localparam logic SEL_D  = 1'b1;

   typedef logic [31:0] word_t;

   // Number of bits needed to hold values 0..maxValue (never less than 1).
   function automatic int widthFor(input int maxValue);
      return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
   endfunction

endpackage

// File: rtl/Select_32.sv
// 32-bit two-way select that steers either the fetch address or the data
// address onto the shared memory port.
module Select_32
   import mem_port_arbiter_pkg::*;
(
   input  logic  en,
   input  word_t A,
   input  word_t B,
   output word_t out
);

   // en picks the data-side source; otherwise the fetch source passes through.
   assign out = (en == SEL_D) ? B : A;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency 32-bit memory port between instruction
// fetch (IF) and data access (D). D normally wins a tie, but IF is forced
// through after STARVE_MAX consecutive D grants that left IF waiting.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
)
(
   input  logic  clk,
   input  logic  rst,

   input  logic  if_req,
   input  word_t if_addr,
   output logic  if_ack,
   output word_t if_rdata,

   input  logic  d_req,
   input  logic  d_we,
   input  word_t d_addr,
   input  word_t d_wdata,
   output logic  d_ack,
   output word_t d_rdata,

   output logic  mem_sel,
   output logic  mem_en,
   output logic  mem_we,
   output word_t mem_addr,
   output word_t mem_wdata,
   input  word_t mem_rdata
);

   localparam int CNT_W = widthFor(MEM_LAT - 1);
   localparam int STV_W = widthFor(STARVE_MAX);

   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STARVE_TOP = STV_W'(STARVE_MAX);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [STV_W-1:0] starve;

   logic busy;
   logic firstCycle;
   logic lastCycle;
   logic grantIf;
   logic grantD;

   // The counter is loaded with MEM_LAT-1 on grant and counts down, so the
   // load value marks the strobe cycle and zero marks the completion cycle.
   // With MEM_LAT = 1 both coincide.
   assign busy       = (state == ST_BUSY_IF) || (state == ST_BUSY_D);
   assign firstCycle = busy && (cnt == CNT_LOAD);
   assign lastCycle  = busy && (cnt == '0);

   // Arbitration only happens in IDLE; D wins ties unless IF has waited out
   // STARVE_MAX D grants already.
   always_comb begin
      grantIf = 1'b0;
      grantD  = 1'b0;
      if (state == ST_IDLE) begin
         if (if_req && d_req) begin
            if (starve == STARVE_TOP) begin
               grantIf = 1'b1;
            end else begin
               grantD = 1'b1;
            end
         end else if (if_req) begin
            grantIf = 1'b1;
         end else if (d_req) begin
            grantD = 1'b1;
         end
      end
   end

   // Transaction sequencer: grant loads the latency counter, the counter runs
   // down while busy, and the completion cycle returns to IDLE. An unused
   // encoding falls back to IDLE so the port can never lock up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grantIf) begin
                  state <= ST_BUSY_IF;
                  cnt   <= CNT_LOAD;
               end else if (grantD) begin
                  state <= ST_BUSY_D;
                  cnt   <= CNT_LOAD;
               end
            end
            ST_BUSY_IF, ST_BUSY_D: begin
               if (lastCycle) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Starvation tracking: count D grants taken while IF was also waiting,
   // saturating at STARVE_MAX, and clear it whenever IF finally gets the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= '0;
      end else if (grantIf) begin
         starve <= '0;
      end else if (grantD && if_req && (starve != STARVE_TOP)) begin
         starve <= starve + STV_W'(1);
      end
   end

   // Mux select is registered on grant and held through IDLE so the memory
   // address stays on the last owner instead of flipping between requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_sel <= SEL_IF;
      end else if (grantIf) begin
         mem_sel <= SEL_IF;
      end else if (grantD) begin
         mem_sel <= SEL_D;
      end
   end

   // Strobe, write enable and acks are decoded from state and counter. They
   // are gated by reset so an aborted transaction never shows a completion.
   assign mem_en = !rst && firstCycle;
   assign mem_we = mem_en && d_we && (state == ST_BUSY_D);
   assign if_ack = !rst && lastCycle && (state == ST_BUSY_IF);
   assign d_ack  = !rst && lastCycle && (state == ST_BUSY_D);

   // Read data is a straight passthrough; each requester qualifies it with
   // its own ack.
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;
   assign mem_wdata = d_wdata;

   Select_32 addr_mux (
      .en  (mem_sel),
      .A   (if_addr),
      .B   (d_addr),
      .out (mem_addr)
   );

endmodule
